// File: rtl/lamp_fpu_div_issue_pkg.sv
// lamp_fpu_div_issue_pkg
// Shared definitions for the bf16 divide issuer.
// Contents: bf16 field widths and bias, the canonical quiet NaN, the bit
// positions inside the 5-bit IEEE flag vector, the issuer FSM state type, and
// the special-operand classifier.
// The optional divider watchdog is enabled with the macro LAMP_DIV_TIMEOUT_EN.
// In that build DIV_TIMEOUT sets the watchdog limit.
package lamp_fpu_div_issue_pkg;

    localparam int LAMP_FLOAT_E_DW   = 8;
    localparam int LAMP_FLOAT_F_DW   = 7;
    localparam int LAMP_FLOAT_E_BIAS = 127;
    localparam int DIV_TIMEOUT       = 15;

    localparam logic [15:0] LAMP_QNAN = 16'h7FC0;

    // flags vector layout: {invalid, divzero, overflow, underflow, inexact}
    localparam int FLAG_INVALID   = 4;
    localparam int FLAG_DIVZERO   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_NORM  = 3'd3,
        ST_OUT   = 3'd4
    } div_state_e;

    typedef struct packed {
        logic        hit;
        logic [15:0] res;
        logic [4:0]  flags;
    } special_t;

    // Resolves every operand pair that must not reach the divider core.
    // The checks run in priority order, and the first match wins.
    // Subnormals are classed as zero.
    function automatic special_t classify_special(input logic [15:0] a, input logic [15:0] b);
        special_t                   r_s;
        logic [LAMP_FLOAT_E_DW-1:0] a_exp_s;
        logic [LAMP_FLOAT_E_DW-1:0] b_exp_s;
        logic [LAMP_FLOAT_F_DW-1:0] a_frac_s;
        logic [LAMP_FLOAT_F_DW-1:0] b_frac_s;
        logic sign_s, a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
        a_exp_s  = a[14:7];
        b_exp_s  = b[14:7];
        a_frac_s = a[6:0];
        b_frac_s = b[6:0];
        sign_s   = a[15] ^ b[15];
        a_zero_s = (a_exp_s == 8'h00);
        b_zero_s = (b_exp_s == 8'h00);
        a_inf_s  = (a_exp_s == 8'hFF) && (a_frac_s == 7'h00);
        b_inf_s  = (b_exp_s == 8'hFF) && (b_frac_s == 7'h00);
        a_nan_s  = (a_exp_s == 8'hFF) && (a_frac_s != 7'h00);
        b_nan_s  = (b_exp_s == 8'hFF) && (b_frac_s != 7'h00);
        r_s.hit   = 1'b1;
        r_s.res   = 16'h0000;
        r_s.flags = 5'b00000;
        if (a_nan_s || b_nan_s) begin
            r_s.res = LAMP_QNAN;
            // A NaN with the quiet bit clear is signalling.
            r_s.flags[FLAG_INVALID] = (a_nan_s && !a_frac_s[6]) || (b_nan_s && !b_frac_s[6]);
        end else if ((a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
            r_s.res = LAMP_QNAN;
            r_s.flags[FLAG_INVALID] = 1'b1;
        end else if (a_inf_s) begin
            r_s.res = {sign_s, 8'hFF, 7'h00};
        end else if (b_zero_s) begin
            r_s.res = {sign_s, 8'hFF, 7'h00};
            r_s.flags[FLAG_DIVZERO] = 1'b1;
        end else if (a_zero_s || b_inf_s) begin
            r_s.res = {sign_s, 15'h0000};
        end else begin
            r_s.hit = 1'b0;
        end
        return r_s;
    endfunction

endpackage

// File: rtl/lamp_fpu_div_round.sv
// lamp_fpu_div_round
// Combinational normalize, round-to-nearest-even and pack stage for a
// fractional-divider quotient. It is shared with the sqrt issuer.
// Ports:
//   res_i   unsigned Q2.14 quotient, in the range (0.5, 2)
//   exp_i   10-bit two's complement biased exponent, before normalization
//   sign_i  result sign
//   res_o   packed bf16 result (saturates to inf, flushes to zero)
//   flags_o IEEE flags: only overflow, underflow and inexact can be set here
module lamp_fpu_div_round
    import lamp_fpu_div_issue_pkg::*;
(
    input  logic [15:0] res_i,
    input  logic [9:0]  exp_i,
    input  logic        sign_i,
    output logic [15:0] res_o,
    output logic [4:0]  flags_o
);

    logic                       hi_s;
    logic [LAMP_FLOAT_F_DW-1:0] mant_s;
    logic [LAMP_FLOAT_F_DW-1:0] mant_rnd_s;
    logic                       guard_s;
    logic                       sticky_s;
    logic                       round_up_s;
    logic                       carry_s;
    logic signed [9:0]          exp_n_s;
    logic signed [9:0]          exp_f_s;

    // Normalize on the integer bit, apply RNE, then range-check the exponent
    always_comb begin
        // Bit 15 cannot be set for in-range operands.
        // If it is, it is treated like an integer bit so the result stays bounded.
        hi_s = res_i[15] | res_i[14];
        if (hi_s) begin
            mant_s   = res_i[13:7];
            guard_s  = res_i[6];
            sticky_s = |res_i[5:0];
            exp_n_s  = $signed(exp_i);
        end else begin
            mant_s   = res_i[12:6];
            guard_s  = res_i[5];
            sticky_s = |res_i[4:0];
            exp_n_s  = $signed(exp_i) - 10'sd1;
        end
        round_up_s = guard_s & (sticky_s | mant_s[0]);
        {carry_s, mant_rnd_s} = {1'b0, mant_s} + {7'd0, round_up_s};
        // A carry-out wraps the fraction to zero and bumps the exponent by one.
        exp_f_s = exp_n_s + $signed({9'd0, carry_s});
        flags_o = 5'b00000;
        if (exp_f_s >= 10'sd255) begin
            res_o = {sign_i, 8'hFF, 7'h00};
            flags_o[FLAG_OVERFLOW] = 1'b1;
            flags_o[FLAG_INEXACT]  = 1'b1;
        end else if (exp_f_s <= 10'sd0) begin
            res_o = {sign_i, 15'h0000};
            flags_o[FLAG_UNDERFLOW] = 1'b1;
            flags_o[FLAG_INEXACT]   = 1'b1;
        end else begin
            res_o = {sign_i, exp_f_s[7:0], mant_rnd_s};
            flags_o[FLAG_INEXACT] = guard_s | sticky_s;
        end
    end

endmodule

// File: rtl/lamp_fpu_div_issue.sv
// lamp_fpu_div_issue
// Initiator of the bf16 divide handshake with the fractional divider core.
// Special operands are resolved locally. Normal operands are issued to the
// core, and the returned quotient is rounded and packed.
// Only one operation is in flight at a time.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   in_valid_i/in_ready_o       operand handshake
//   a_i, b_i                    bf16 dividend and divisor
//   doDiv_o, n_o, d_o           start pulse and {1,frac} significands to the core
//   res_i, valid_i              Q2.14 quotient and its one-cycle valid from the core
//   out_valid_o/out_ready_i     result handshake
//   res_o, flags_o              bf16 quotient, {invalid,divzero,overflow,underflow,inexact}
// Optional build macro LAMP_DIV_TIMEOUT_EN enables a watchdog in WAIT.
// With the watchdog, a missing core response is reported as invalid qNaN.
module lamp_fpu_div_issue
    import lamp_fpu_div_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic        doDiv_o,
    output logic [7:0]  n_o,
    output logic [7:0]  d_o,
    input  logic [15:0] res_i,
    input  logic        valid_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [15:0] res_o,
    output logic [4:0]  flags_o
);

    div_state_e  state_r, state_nxt_s;
    logic        in_ready_r, do_div_r, out_valid_r;
    logic        in_ready_nxt_s, do_div_nxt_s, out_valid_nxt_s;
    logic [7:0]  n_r, d_r;
    logic        sign_r;
    logic [9:0]  exp_r;
    logic [9:0]  exp_calc_s;
    logic [15:0] res_lat_r;
    logic [15:0] res_r;
    logic [4:0]  flags_r;
    logic [15:0] rnd_res_s;
    logic [4:0]  rnd_flags_s;
    logic        accept_s;
    logic        timeout_s;
    special_t    special_s;

    assign special_s  = classify_special(a_i, b_i);
    assign accept_s   = (state_r == ST_IDLE) && in_ready_r && in_valid_i;
    assign exp_calc_s = {2'b00, a_i[14:7]} - {2'b00, b_i[14:7]} + 10'(LAMP_FLOAT_E_BIAS);

`ifdef LAMP_DIV_TIMEOUT_EN
    localparam logic [3:0] WD_LAST = 4'(DIV_TIMEOUT - 1);
    logic [3:0] wd_cnt_r;

    // Watchdog: counts consecutive WAIT cycles and restarts whenever WAIT is left
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_r <= 4'd0;
        end else if (state_r == ST_WAIT) begin
            wd_cnt_r <= wd_cnt_r + 4'd1;
        end else begin
            wd_cnt_r <= 4'd0;
        end
    end

    assign timeout_s = (state_r == ST_WAIT) && !valid_i && (wd_cnt_r == WD_LAST);
`else
    assign timeout_s = 1'b0;
`endif

    lamp_fpu_div_round u_round (
        .res_i   (res_lat_r),
        .exp_i   (exp_r),
        .sign_i  (sign_r),
        .res_o   (rnd_res_s),
        .flags_o (rnd_flags_s)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (special_s.hit) begin
                        state_nxt_s = ST_OUT;
                    end else begin
                        state_nxt_s = ST_ISSUE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (valid_i) begin
                    state_nxt_s = ST_NORM;
                end else if (timeout_s) begin
                    state_nxt_s = ST_OUT;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_NORM: state_nxt_s = ST_OUT;
            ST_OUT: begin
                if (out_ready_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_OUT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output decode from the next state.
    // The decoded values are registered so the handshake outputs come straight from flops.
    always_comb begin
        in_ready_nxt_s  = 1'b0;
        do_div_nxt_s    = 1'b0;
        out_valid_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_IDLE:  in_ready_nxt_s  = 1'b1;
            ST_ISSUE: do_div_nxt_s    = 1'b1;
            ST_OUT:   out_valid_nxt_s = 1'b1;
            default: begin
                in_ready_nxt_s  = 1'b0;
                do_div_nxt_s    = 1'b0;
                out_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_r  <= 1'b0;
            do_div_r    <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= in_ready_nxt_s;
            do_div_r    <= do_div_nxt_s;
            out_valid_r <= out_valid_nxt_s;
        end
    end

    // Datapath: operand capture, quotient latch and result load per state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_r       <= 8'h00;
            d_r       <= 8'h00;
            sign_r    <= 1'b0;
            exp_r     <= 10'd0;
            res_lat_r <= 16'h0000;
            res_r     <= 16'h0000;
            flags_r   <= 5'b00000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        n_r    <= {1'b1, a_i[6:0]};
                        d_r    <= {1'b1, b_i[6:0]};
                        sign_r <= a_i[15] ^ b_i[15];
                        exp_r  <= exp_calc_s;
                        if (special_s.hit) begin
                            res_r   <= special_s.res;
                            flags_r <= special_s.flags;
                        end
                    end
                end
                ST_WAIT: begin
                    if (valid_i) begin
                        res_lat_r <= res_i;
                    end else if (timeout_s) begin
                        res_r   <= LAMP_QNAN;
                        flags_r <= 5'b10000;
                    end
                end
                ST_NORM: begin
                    res_r   <= rnd_res_s;
                    flags_r <= rnd_flags_s;
                end
                default: begin
                    res_r <= res_r;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_r;
    assign doDiv_o     = do_div_r;
    assign out_valid_o = out_valid_r;
    assign n_o         = n_r;
    assign d_o         = d_r;
    assign res_o       = res_r;
    assign flags_o     = flags_r;

endmodule

// File: tb/tb_lamp_fpu_div_issue.sv
// Self-checking bench for lamp_fpu_div_issue.
// Includes a divider-core responder and a bf16 reference model.
module tb_lamp_fpu_div_issue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [15:0] a_i = 16'h0000;
    logic [15:0] b_i = 16'h0000;
    logic        doDiv_o;
    logic [7:0]  n_o, d_o;
    logic [15:0] res_i = 16'h0000;
    logic        valid_i = 1'b0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [15:0] res_o;
    logic [4:0]  flags_o;

    int checks = 0;
    int failures = 0;

    lamp_fpu_div_issue dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .a_i(a_i), .b_i(b_i), .doDiv_o(doDiv_o), .n_o(n_o), .d_o(d_o),
        .res_i(res_i), .valid_i(valid_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .res_o(res_o), .flags_o(flags_o)
    );

    always #5 clk = ~clk;

    // Reference: bf16 divide from the rules, using integer arithmetic on values
    function automatic void model_div(input logic [15:0] a, input logic [15:0] b,
                                      output logic [15:0] res, output logic [4:0] fl,
                                      output bit special);
        int ea, eb, fa, fb, n, d, q, unit, m, rem, e;
        bit s, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
        ea = int'(a[14:7]); eb = int'(b[14:7]); fa = int'(a[6:0]); fb = int'(b[6:0]);
        s = a[15] ^ b[15];
        a_nan = (ea == 255) && (fa != 0); b_nan = (eb == 255) && (fb != 0);
        a_snan = a_nan && (fa < 64); b_snan = b_nan && (fb < 64);
        a_inf = (ea == 255) && (fa == 0); b_inf = (eb == 255) && (fb == 0);
        a_zero = (ea == 0); b_zero = (eb == 0);
        special = 1; fl = 5'b00000; res = 16'h0000;
        if (a_nan || b_nan) begin
            res = 16'h7FC0; fl = (a_snan || b_snan) ? 5'b10000 : 5'b00000;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            res = 16'h7FC0; fl = 5'b10000;
        end else if (a_inf) begin
            res = {s, 15'h7F80};
        end else if (b_zero) begin
            res = {s, 15'h7F80}; fl = 5'b01000;
        end else if (a_zero || b_inf) begin
            res = {s, 15'h0000};
        end else begin
            special = 0;
            n = 128 + fa; d = 128 + fb;
            q = (n * 16384) / d;
            e = ea - eb + 127;
            if (q >= 16384) unit = 128;
            else begin unit = 64; e = e - 1; end
            m = q / unit; rem = q % unit;
            if (rem > unit / 2 || (rem == unit / 2 && (m % 2) == 1)) m = m + 1;
            if (m == 256) begin m = 128; e = e + 1; end
            if (e >= 255) begin res = {s, 15'h7F80}; fl = 5'b00101; end
            else if (e <= 0) begin res = {s, 15'h0000}; fl = 5'b00011; end
            else begin
                res = {s, 8'(e), 7'(m - 128)};
                fl = (rem != 0) ? 5'b00001 : 5'b00000;
            end
        end
    endfunction

    function automatic logic [15:0] rand_bf16();
        logic [15:0] v;
        int k;
        k = $urandom_range(0, 9);
        v[15] = 1'($urandom_range(0, 1));
        v[6:0] = 7'($urandom_range(0, 127));
        case (k)
            0: v[14:7] = 8'h00;
            1: begin v[14:7] = 8'hFF; v[6:0] = 7'h00; end
            2: begin v[14:7] = 8'hFF; v[6:0] = 7'($urandom_range(1, 127)); end
            3, 4: v[14:7] = 8'($urandom_range(1, 254));
            default: v[14:7] = 8'($urandom_range(110, 144));
        endcase
        return v;
    endfunction

    // Drives one operation and plays the divider core: q = floor(n*2^14/d).
    // Cycle c counts negedges after the accepting posedge.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input bit respond,
                         input int hold, output logic [15:0] res, output logic [4:0] fl,
                         output int n_dodiv, output logic [7:0] n_seen, output logic [7:0] d_seen,
                         output int out_cyc, output int valid_cyc, output bit stable,
                         output bit timed_out);
        int c, fire;
        logic [15:0] q;
        bit got;
        n_dodiv = 0; out_cyc = -1; valid_cyc = -1; stable = 1; timed_out = 0;
        res = 16'h0000; fl = 5'b00000; n_seen = 8'h00; d_seen = 8'h00;
        fire = -1; q = 16'h0000; got = 0;
        for (int i = 0; i < 20 && !in_ready_o; i++) @(negedge clk);
        if (!in_ready_o) begin timed_out = 1; return; end
        a_i = a; b_i = b; in_valid_i = 1'b1;
        @(negedge clk);
        in_valid_i = 1'b0;
        c = 1;
        while (!got && c < 100) begin
            if (doDiv_o) begin
                n_dodiv++; n_seen = n_o; d_seen = d_o;
                q = 16'((int'(n_o) * 16384) / int'(d_o));
                if (respond) fire = c + $urandom_range(1, 4);
            end
            if (out_valid_o) begin
                got = 1; out_cyc = c; res = res_o; fl = flags_o;
            end else begin
                valid_i = (c == fire);
                res_i = (c == fire) ? q : 16'h0000;
                if (c == fire) valid_cyc = c;
                @(negedge clk);
                c++;
            end
        end
        valid_i = 1'b0;
        if (!got) begin timed_out = 1; return; end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (res_o !== res || flags_o !== fl || out_valid_o !== 1'b1) stable = 0;
        end
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        checks++;
        if ({in_ready_o, doDiv_o, out_valid_o} !== 3'b000) begin
            failures++; $display("FAIL reset_handshake got=%b want=000", {in_ready_o, doDiv_o, out_valid_o});
        end
        checks++;
        if ({res_o, flags_o} !== 21'h0) begin
            failures++; $display("FAIL reset_result got=%h/%b want=0000/00000", res_o, flags_o);
        end
        checks++;
        if ({n_o, d_o} !== 16'h0000) begin
            failures++; $display("FAIL reset_nd got=%h want=0000", {n_o, d_o});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready_o !== 1'b1) begin
            failures++; $display("FAIL ready_after_reset got=%b want=1", in_ready_o);
        end
    endtask

    task automatic test_directed();
        logic [15:0] va [0:13];
        logic [15:0] vb [0:13];
        logic [15:0] vr [0:13];
        logic [4:0]  vf [0:13];
        logic [13:0] vs;
        logic [15:0] r; logic [4:0] f; logic [7:0] ns, ds;
        int nd, oc, vc; bit st, to;
        va = '{16'h3F80, 16'h40C0, 16'h3F80, 16'h3F80, 16'h0000, 16'h7F00, 16'h0080,
               16'h7F81, 16'hFFC1, 16'hFF80, 16'h7F80, 16'h0001, 16'hBF80, 16'h3F80};
        vb = '{16'h3F80, 16'h4040, 16'h4040, 16'h0000, 16'h0000, 16'h0080, 16'h7F00,
               16'h3F80, 16'h0000, 16'h8000, 16'h7F80, 16'h3F80, 16'h7F80, 16'h0001};
        vr = '{16'h3F80, 16'h4000, 16'h3EAB, 16'h7F80, 16'h7FC0, 16'h7F80, 16'h0000,
               16'h7FC0, 16'h7FC0, 16'h7F80, 16'h7FC0, 16'h0000, 16'h8000, 16'h7F80};
        vf = '{5'b00000, 5'b00000, 5'b00001, 5'b01000, 5'b10000, 5'b00101, 5'b00011,
               5'b10000, 5'b00000, 5'b00000, 5'b10000, 5'b00000, 5'b00000, 5'b01000};
        // bit i set: case i is resolved without the divider
        vs = 14'b11111110011000;
        for (int i = 0; i < 14; i++) begin
            do_op(va[i], vb[i], 1'b1, 0, r, f, nd, ns, ds, oc, vc, st, to);
            checks++;
            if (to || r !== vr[i] || f !== vf[i]) begin
                failures++;
                $display("FAIL directed_%0d %h/%h got=%h/%b want=%h/%b timeout=%0d",
                         i, va[i], vb[i], r, f, vr[i], vf[i], to);
            end
            checks++;
            if (vs[i] ? (nd != 0 || oc != 1) : (nd != 1 || oc != vc + 2)) begin
                failures++;
                $display("FAIL directed_timing_%0d dodiv=%0d out_cyc=%0d valid_cyc=%0d special=%0d",
                         i, nd, oc, vc, vs[i]);
            end
            if (i == 0 || i == 2) begin
                checks++;
                if (ns !== 8'h80 || ds !== ((i == 0) ? 8'h80 : 8'hC0)) begin
                    failures++; $display("FAIL directed_nd_%0d got=%h/%h", i, ns, ds);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] r; logic [4:0] f; logic [7:0] ns, ds;
        int nd, oc, vc; bit st, to;
        do_op(16'h3F80, 16'h4040, 1'b1, 5, r, f, nd, ns, ds, oc, vc, st, to);
        checks++;
        if (to || r !== 16'h3EAB || f !== 5'b00001) begin
            failures++; $display("FAIL backpressure_value got=%h/%b want=3eab/00001", r, f);
        end
        checks++;
        if (!st) begin
            failures++; $display("FAIL backpressure_stable got=unstable want=stable");
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b, r, er; logic [4:0] f, ef; logic [7:0] ns, ds;
        int nd, oc, vc; bit st, to, sp;
        for (int i = 0; i < 80; i++) begin
            a = rand_bf16(); b = rand_bf16();
            model_div(a, b, er, ef, sp);
            do_op(a, b, 1'b1, $urandom_range(0, 2), r, f, nd, ns, ds, oc, vc, st, to);
            checks++;
            if (to || r !== er || f !== ef) begin
                failures++;
                $display("FAIL random_%0d %h/%h got=%h/%b want=%h/%b timeout=%0d", i, a, b, r, f, er, ef, to);
            end
            checks++;
            if (sp ? (nd != 0 || oc != 1) : (nd != 1 || oc != vc + 2 || ns !== {1'b1, a[6:0]} || ds !== {1'b1, b[6:0]})) begin
                failures++;
                $display("FAIL random_issue_%0d dodiv=%0d out_cyc=%0d valid_cyc=%0d n=%h d=%h", i, nd, oc, vc, ns, ds);
            end
        end
    endtask

    task automatic test_reset_in_wait();
        bit seen, spurious;
        logic [15:0] r; logic [4:0] f; logic [7:0] ns, ds;
        int nd, oc, vc; bit st, to;
        seen = 0; spurious = 0;
        for (int i = 0; i < 20 && !in_ready_o; i++) @(negedge clk);
        a_i = 16'h7F00; b_i = 16'h0080; in_valid_i = 1'b1;
        @(negedge clk);
        in_valid_i = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            if (doDiv_o) seen = 1;
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            failures++; $display("FAIL rst_wait_issue got=no_doDiv want=doDiv");
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        valid_i = 1'b1; res_i = 16'h4000;
        @(negedge clk);
        valid_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid_o) spurious = 1;
            @(negedge clk);
        end
        checks++;
        if (spurious || in_ready_o !== 1'b1) begin
            failures++; $display("FAIL rst_wait_ignore out_valid_seen=%0d ready=%b want=0/1", spurious, in_ready_o);
        end
        do_op(16'h40C0, 16'h4040, 1'b1, 0, r, f, nd, ns, ds, oc, vc, st, to);
        checks++;
        if (to || r !== 16'h4000 || f !== 5'b00000) begin
            failures++; $display("FAIL rst_wait_recover got=%h/%b want=4000/00000", r, f);
        end
    endtask

`ifdef LAMP_DIV_TIMEOUT_EN
    task automatic test_timeout();
        logic [15:0] r; logic [4:0] f; logic [7:0] ns, ds;
        int nd, oc, vc; bit st, to;
        do_op(16'h3F80, 16'h4040, 1'b0, 0, r, f, nd, ns, ds, oc, vc, st, to);
        checks++;
        if (to || r !== 16'h7FC0 || f !== 5'b10000 || oc != 17) begin
            failures++; $display("FAIL timeout got=%h/%b out_cyc=%0d want=7fc0/10000 out_cyc=17", r, f, oc);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_in_wait();
`ifdef LAMP_DIV_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lamp_fpu_div_issue.md
Name: lamp_fpu_div_issue

Overview:
Initiator side of the bf16 fractional-divider handshake. Accepts bf16 operand pairs over a valid/ready interface, unpacks them and resolves special cases locally. For normal operands it issues one doDiv pulse with 8-bit significands to the Goldschmidt fractional divider core, waits for its valid, then normalizes, rounds (RNE), packs and presents the bf16 quotient with IEEE flags on a downstream valid/ready interface.

Parameters:
LAMP_FLOAT_E_DW, 8, exponent width
LAMP_FLOAT_F_DW, 7, stored fraction width
LAMP_FLOAT_E_BIAS, 127, exponent bias
DIV_TIMEOUT, 15, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
in_valid_i  in  1  operand pair valid
in_ready_o  out  1  block can accept an operand pair
a_i  in  16  bf16 dividend
b_i  in  16  bf16 divisor
doDiv_o  out  1  one-cycle start pulse to the divider core
n_o  out  8  dividend significand {1,frac}
d_o  out  8  divisor significand {1,frac}
res_i  in  16  divider quotient, unsigned fixed point Q2.14
valid_i  in  1  divider result valid, one-cycle pulse
out_valid_o  out  1  result valid
out_ready_i  in  1  consumer accepts the result
res_o  out  16  bf16 quotient
flags_o  out  5  {invalid, divzero, overflow, underflow, inexact}

Behaviour:
- Reset: async, active-high. All outputs are 0, FSM is IDLE, internal registers are cleared. Reset mid-operation abandons the operation. Any divider valid_i that arrives later is ignored because the FSM is not in WAIT.
- States: IDLE, ISSUE, WAIT, NORM, OUT.
- IDLE: in_ready_o=1. On in_valid_i, capture the operands.
  - Special case detected: go directly to OUT.
  - Otherwise: go to ISSUE.
- ISSUE: doDiv_o=1 for exactly this cycle, with n_o/d_o stable. Then go to WAIT. n_o/d_o stay held until NORM.
- WAIT: stay until valid_i, then latch res_i and go to NORM. valid_i in any other state is ignored.
- NORM:
  - If res_i[14]=1: mantissa=res_i[13:7], guard=res_i[6], sticky=|res_i[5:0].
  - Else: exponent-1, mantissa=res_i[12:6], guard=res_i[5], sticky=|res_i[4:0].
  - Apply RNE. On a mantissa carry-out, exponent+1.
  - Pack and go to OUT.
- OUT: out_valid_o=1, with res_o and flags_o stable until out_ready_i. On the handshake go to IDLE. No new operand is accepted before then, so there is one operation in flight.
- Exponent arithmetic: 10-bit signed, exp = ea - eb + bias.
  - Final exp ≥ 255: ±inf, overflow=1, inexact=1.
  - Final exp ≤ 0: ±0 (flush-to-zero), underflow=1, inexact=1.
  - inexact = guard|sticky for normal results.
- Sign = sa ^ sb for every result, including zero and inf. NaN results are always canonical qNaN 0x7FC0.
- Subnormal inputs are treated as zero (DAZ).
- Special-case priority (first match wins):
  - Either input NaN → 0x7FC0. invalid=1 only for sNaN.
  - 0/0 or inf/inf → 0x7FC0, invalid=1.
  - inf/x → ±inf.
  - x/0 → ±inf, divzero=1.
  - 0/x or x/inf → ±0.
- Latency:
  - Special case: capture at cycle t, out_valid_o at t+1.
  - Normal: doDiv_o at t+1, out_valid_o two cycles after valid_i.

Optional Feature:
LAMP_DIV_TIMEOUT_EN
- Defined: a 4-bit watchdog counter runs in WAIT. If valid_i is absent for DIV_TIMEOUT cycles, the block goes to OUT with res_o=0x7FC0 and flags_o=5'b10000.
- Undefined: no counter; WAIT waits indefinitely.

Decomposition:
- Shared package: bf16 field widths, bias, 0x7FC0 qNaN constant, the flags bit-index constants, the FSM state typedef, and a special-case classification function.
- Sub-module lamp_fpu_div_round: combinational normalize/RNE/pack from latched res_i plus exponent and sign. It is reused by the future sqrt issuer.

Test Plan:
- 0x3F80 / 0x3F80, divider model returns 0x4000 → one doDiv_o pulse with n_o=d_o=0x80; res_o=0x3F80, flags=0.
- 0x40C0 / 0x4040 (6/3) → res_o=0x4000, flags=0, out_valid_o two cycles after valid_i.
- 0x3F80 / 0x4040 (1/3) → res_o=0x3EAB, inexact=1. Hold out_ready_i=0 for 5 cycles; outputs stay stable.
- 0x3F80 / 0x0000 → res_o=0x7F80, divzero=1, no doDiv_o, out_valid_o one cycle after accept. 0x0000 / 0x0000 → 0x7FC0, invalid=1.
- 0x7F00 / 0x0080 → res_o=0x7F80, overflow=1, inexact=1. Assert rst in WAIT, then pulse valid_i → no out_valid_o.
- With LAMP_DIV_TIMEOUT_EN, withhold valid_i → out_valid_o after 15 WAIT cycles with 0x7FC0 and flags=5'b10000.
